arith_writeback: RTL
====================

Name: arith_writeback

Overview:
- Sequential consumer of the arithmetic unit's 32-bit result bus; sits between the arithmetic unit and the CPU's 16-bit register file write port.
- Accepts {result, opcode, destination register} through a valid/ready handshake and turns each one into one or two register-file writes.
- MUL writes both halves (lo to rd, hi to rd+1); ADD/SUB/DIV write only the low half.
- Also maintains the zero flag and a sticky divide-error flag for the FSM controller.

Parameters:
- REG_AW, 3, register-file address width (8 registers).
- DATA_W, 16, register width; the result bus is 2*DATA_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  result bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- in_result  in  32  arithmetic result.
- in_opcode  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, others NOP.
- in_rd  in  REG_AW  destination register.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  16  write data.
- done  out  1  one-cycle pulse: bundle fully retired.
- zero_flag  out  1  last retired result was zero.
- div_err  out  1  sticky divide-by-zero flag.
- err_clr  in  1  clears div_err.

Behaviour:
- Reset (synchronous, active-high, on clk): state=IDLE; in_ready=1; rf_we=0; rf_waddr=0; rf_wdata=0; done=0; zero_flag=0; div_err=0.
- Reset mid-write aborts the bundle and drops any pending hi write. No write or done is issued in the reset cycle or after it.
- Accept rule: transfer occurs on in_valid && in_ready at a rising edge. The block latches result, opcode and rd in that cycle.
- States:
  - IDLE: in_ready=1. On accept of ADD/SUB/DIV/MUL, go to WR_LO. On accept of NOP, go to NOPDONE.
  - WR_LO: rf_we=1, rf_waddr=rd, rf_wdata=result[15:0]. If opcode=MUL, go to WR_HI. Otherwise this is the last cycle: done=1, and go to IDLE or WR_LO/NOPDONE if a new bundle is accepted.
  - WR_HI: rf_we=1, rf_waddr=rd+1 modulo 2^REG_AW (rd=7 wraps to 0), rf_wdata=result[31:16]. done=1. Next state as for the last cycle of WR_LO.
  - NOPDONE: no write; done=1. Next state as for a last cycle.
- in_ready is 1 in IDLE and in every last cycle (WR_LO for non-MUL, WR_HI, NOPDONE). It is 0 in WR_LO for MUL.
- Throughput: back-to-back bundles retire at one per cycle for ADD/SUB/DIV, two cycles for MUL. There are no bubbles.
- Latency: first write occurs the cycle after accept.
- Registered outputs: rf_we, rf_waddr, rf_wdata and done are registered state decodes and hold stable for the whole cycle. When rf_we=0, rf_waddr and rf_wdata hold their last values.
- zero_flag: updated in the done cycle and holds until the next done.
  - MUL: set when the full 32-bit result==0.
  - ADD/SUB/DIV: set when result[15:0]==0.
  - NOP: unchanged.
- div_err: set in the WR_LO cycle of a DIV whose result==32'hFFFF_FFFF (divide-by-zero code). The low half 16'hFFFF is still written.
  - err_clr clears div_err.
  - Set and clear in the same cycle: set wins.
  - Cleared only by err_clr or rst.
- in_valid while in_ready=0: the bundle is not taken, and the upstream must hold it stable.

Decomposition:
- Shared CPU package:
  - arith_op_e enum (ADD=3'b000, SUB=3'b001, MUL=3'b010, DIV=3'b011).
  - DIV_BY_ZERO_CODE=32'hFFFF_FFFF.
  - wb_state_e (IDLE, WR_LO, WR_HI, NOPDONE).
- No sub-module; a single FSM plus a latch register is natural.

Test Plan:
- ADD: accept result=32'h0000_1234, rd=3 -> next cycle rf_we=1, waddr=3, wdata=16'h1234, done=1. zero_flag=0. in_ready stays 1.
- MUL: accept result=32'h0001_0000, rd=7 -> cycle 1: waddr=7, wdata=16'h0000. Cycle 2: waddr=0 (wrap), wdata=16'h0001, done=1. zero_flag=0. in_ready=0 during cycle 1 only.
- DIV by zero: accept DIV result=32'hFFFF_FFFF, rd=2 -> waddr=2, wdata=16'hFFFF, div_err=1 and it stays 1 across subsequent ADDs.
  - Then err_clr=1 together with another DIV-by-zero -> div_err remains 1.
  - err_clr alone -> div_err=0.
- Back-to-back: in_valid held high with SUB result=0 (rd=1), then ADD result=5 (rd=2) -> consecutive write cycles to 1 then 2 with no bubble. zero_flag=1 then 0.
- NOP and reset: opcode=3'b111 -> done pulse, no rf_we, zero_flag unchanged.
  - Assert rst during WR_LO of a MUL -> no WR_HI write.
  - After reset, all outputs are at reset values and in_ready=1.

Source files
------------

// File: rtl/arith_writeback_pkg.sv
// Shared definitions for the arithmetic-unit writeback stage: opcode and
// FSM state encodings, the divider's divide-by-zero result code, and a
// small opcode classification helper.
package arith_writeback_pkg;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        MUL = 3'b010,
        DIV = 3'b011
    } arith_op_e;

    // The divider reports a zero divisor by returning all ones.
    localparam logic [31:0] DIV_BY_ZERO_CODE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_LO   = 2'd1,
        WR_HI   = 2'd2,
        NOPDONE = 2'd3
    } wb_state_e;

    // Opcodes 3'b1xx are NOPs; everything below that writes the register file.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/arith_writeback.sv
// Writeback stage between the arithmetic unit and the 16-bit register file
// write port. Each accepted {result, opcode, rd} bundle becomes one write
// (ADD/SUB/DIV), two writes lo->rd then hi->rd+1 (MUL), or none (NOP).
// All register-file outputs and done are registered decodes of the next
// state, so a write appears the cycle after the bundle is accepted and a
// new bundle can be taken in every last cycle without a bubble.
module arith_writeback
    import arith_writeback_pkg::*;
#(
    parameter int REG_AW = 3,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_W-1:0]   in_result,
    input  logic [2:0]            in_opcode,
    input  logic [REG_AW-1:0]     in_rd,
    output logic                  rf_we,
    output logic [REG_AW-1:0]     rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  done,
    output logic                  zero_flag,
    output logic                  div_err,
    input  logic                  err_clr
);

    wb_state_e             state_q, state_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic [2:0]            op_q, op_d;
    logic [REG_AW-1:0]     rd_q, rd_d;

    logic                  rf_we_q, rf_we_d;
    logic [REG_AW-1:0]     rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
    logic                  done_q, done_d;
    logic                  zero_q, zero_d;
    logic                  div_err_q, div_err_d;

    logic                  last_cycle;
    logic                  accept;

    // The bundle currently being retired finishes this cycle, so the
    // upstream may hand over the next one now.
    assign last_cycle = ((state_q == WR_LO) && (op_q != MUL)) ||
                        (state_q == WR_HI) ||
                        (state_q == NOPDONE);
    assign in_ready   = (state_q == IDLE) || last_cycle;
    assign accept     = in_valid && in_ready;

    // Next state and bundle latch.
    always_comb begin
        state_d  = IDLE;
        result_d = result_q;
        op_d     = op_q;
        rd_d     = rd_q;
        if (accept) begin
            result_d = in_result;
            op_d     = in_opcode;
            rd_d     = in_rd;
            state_d  = is_arith_op(in_opcode) ? WR_LO : NOPDONE;
        end else if ((state_q == WR_LO) && (op_q == MUL)) begin
            state_d = WR_HI;
        end
    end

    // Output decode of the next state, so outputs are stable registers.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        done_d     = 1'b0;
        zero_d     = zero_q;
        div_err_d  = div_err_q;
        if (err_clr) begin
            div_err_d = 1'b0;
        end
        case (state_d)
            WR_LO: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = rd_d;
                rf_wdata_d = result_d[DATA_W-1:0];
                if (op_d != MUL) begin
                    done_d = 1'b1;
                    zero_d = (result_d[DATA_W-1:0] == '0);
                end
                // A new error outranks a simultaneous clear.
                if ((op_d == DIV) && (result_d == DIV_BY_ZERO_CODE)) begin
                    div_err_d = 1'b1;
                end
            end
            WR_HI: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = rd_d + REG_AW'(1);
                rf_wdata_d = result_d[2*DATA_W-1:DATA_W];
                done_d     = 1'b1;
                zero_d     = (result_d == '0);
            end
            NOPDONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, latch and output registers; reset abandons any bundle in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            result_q   <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            done_q     <= 1'b0;
            zero_q     <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            done_q     <= done_d;
            zero_q     <= zero_d;
            div_err_q  <= div_err_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign done      = done_q;
    assign zero_flag = zero_q;
    assign div_err   = div_err_q;

endmodule
